// File: rtl/md_scheduler.sv
// Multiply/divide scheduler that owns HI/LO. It computes the 64-bit result at issue,
// holds it in pending registers for a fixed busy period, then commits it.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_en,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_md_sel,
    output logic [31:0] E_md_out,
    input  logic        D_md_use,
    output logic        D_md_stall,
    output logic        busy
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          commit_ok_q, commit_ok_d;

    logic          is_start;
    logic [63:0]   a_sx, b_sx, prod_s, prod_u;
    logic [31:0]   a_mag, b_mag_raw, b_mag, b_div_u;
    logic [31:0]   qu, ru, qm, rm, qs, rs;
    logic [31:0]   res_hi, res_lo;
    logic [CW-1:0] res_cycles;

    assign is_start = E_md_en & ~E_md_op[2];

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign a_sx   = {{32{E_A[31]}}, E_A};
    assign b_sx   = {{32{E_B[31]}}, E_B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // A zero divisor is replaced by one so the datapath never sees x/0; that result is never committed.
    assign a_mag     = E_A[31] ? (32'd0 - E_A) : E_A;
    assign b_mag_raw = E_B[31] ? (32'd0 - E_B) : E_B;
    assign b_mag     = (b_mag_raw == 32'd0) ? 32'd1 : b_mag_raw;
    assign b_div_u   = (E_B == 32'd0) ? 32'd1 : E_B;
    assign qu        = E_A / b_div_u;
    assign ru        = E_A % b_div_u;
    assign qm        = a_mag / b_mag;
    assign rm        = a_mag % b_mag;
    assign qs        = (E_A[31] ^ E_B[31]) ? (32'd0 - qm) : qm;
    assign rs        = E_A[31] ? (32'd0 - rm) : rm;

    always_comb begin
        res_hi     = prod_s[63:32];
        res_lo     = prod_s[31:0];
        res_cycles = CW'(MULT_CYCLES);
        case (E_md_op[1:0])
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                res_hi     = rs;
                res_lo     = qs;
                res_cycles = CW'(DIV_CYCLES);
            end
            default: begin
                res_hi     = ru;
                res_lo     = qu;
                res_cycles = CW'(DIV_CYCLES);
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        commit_ok_d = commit_ok_q;
        case (state_q)
            IDLE: begin
                if (is_start) begin
                    state_d     = RUN;
                    count_d     = res_cycles;
                    pend_hi_d   = res_hi;
                    pend_lo_d   = res_lo;
                    commit_ok_d = ~(E_md_op[1] & (E_B == 32'd0));
                end else if (E_md_en && E_md_op == 3'd4) begin
                    hi_d = E_A;
                end else if (E_md_en && E_md_op == 3'd5) begin
                    lo_d = E_A;
                end
            end
            default: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = IDLE;
                    if (commit_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            commit_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            commit_ok_q <= commit_ok_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign E_md_out   = E_md_sel ? hi_q : lo_q;
    assign D_md_stall = D_md_use & (busy | is_start);

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: HI/LO moves, mult/div results and latency,
// stall window, reset abort, and ops issued while busy.
module tb_md_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        E_md_en;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_md_sel;
    logic [31:0] E_md_out;
    logic        D_md_use;
    logic        D_md_stall;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_md_en    (E_md_en),
        .E_md_op    (E_md_op),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_md_sel   (E_md_sel),
        .E_md_out   (E_md_out),
        .D_md_use   (D_md_use),
        .D_md_stall (D_md_stall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [31:0] hi_rd, lo_rd;
        reset = 1'b1; E_md_en = 1'b0; E_md_op = 3'd0; E_A = '0; E_B = '0;
        E_md_sel = 1'b0; D_md_use = 1'b1;
        #2;
        E_md_sel = 1'b1; #1 hi_rd = E_md_out;
        E_md_sel = 1'b0; #1 lo_rd = E_md_out;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++; if (D_md_stall !== 1'b0) begin n_bad++; $display("FAIL reset stall: got %b expected 0", D_md_stall); end
        n_cmp++; if (hi_rd !== 32'h0) begin n_bad++; $display("FAIL reset HI: got %h expected 00000000", hi_rd); end
        n_cmp++; if (lo_rd !== 32'h0) begin n_bad++; $display("FAIL reset LO: got %h expected 00000000", lo_rd); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        D_md_use = 1'b0;
        $display("reset: HI=%h LO=%h busy=%b", hi_rd, lo_rd, busy);
    endtask

    task automatic test_mt();
        logic [31:0] hi_rd, lo_rd;
        @(posedge clk); #1;
        E_md_en = 1'b1; E_md_op = 3'd4; E_A = 32'h12345678; D_md_use = 1'b1;
        @(negedge clk);
        n_cmp++; if (D_md_stall !== 1'b0) begin n_bad++; $display("FAIL mthi stall: got %b expected 0", D_md_stall); end
        @(posedge clk); #1;
        E_md_op = 3'd5; E_A = 32'h9ABCDEF0;
        @(negedge clk);
        E_md_sel = 1'b1; #1 hi_rd = E_md_out;
        n_cmp++; if (hi_rd !== 32'h12345678) begin n_bad++; $display("FAIL mthi visible next cycle: got %h expected 12345678", hi_rd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        E_md_op = 3'd6; E_A = 32'hFFFFFFFF;
        @(negedge clk);
        E_md_sel = 1'b0; #1 lo_rd = E_md_out;
        n_cmp++; if (lo_rd !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL mtlo visible: got %h expected 9abcdef0", lo_rd); end
        @(posedge clk); #1;
        E_md_op = 3'd7; E_B = 32'h00000001;
        @(posedge clk); #1;
        E_md_en = 1'b0; D_md_use = 1'b0;
        @(negedge clk);
        E_md_sel = 1'b1; #1 hi_rd = E_md_out;
        E_md_sel = 1'b0; #1 lo_rd = E_md_out;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noop busy: got %b expected 0", busy); end
        n_cmp++; if (hi_rd !== 32'h12345678) begin n_bad++; $display("FAIL noop HI: got %h expected 12345678", hi_rd); end
        n_cmp++; if (lo_rd !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL noop LO: got %h expected 9abcdef0", lo_rd); end
        $display("mthi/mtlo/noop: HI=%h LO=%h", hi_rd, lo_rd);
    endtask

    // Issue one multi-cycle op and check busy, stall and HI/LO every cycle until commit.
    task automatic test_md_op(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int n,
                              input logic [31:0] old_hi, input logic [31:0] old_lo,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input logic use_d);
        logic [31:0] hi_rd, lo_rd;
        @(posedge clk); #1;
        E_md_en = 1'b1; E_md_op = op; E_A = a; E_B = b; D_md_use = use_d;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy at issue: got %b expected 0", name, busy); end
        n_cmp++; if (D_md_stall !== use_d) begin n_bad++; $display("FAIL %s stall at issue: got %b expected %b", name, D_md_stall, use_d); end
        @(posedge clk); #1;
        E_md_en = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            E_md_sel = 1'b1; #1 hi_rd = E_md_out;
            E_md_sel = 1'b0; #1 lo_rd = E_md_out;
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy t+%0d: got %b expected 1", name, i, busy); end
            n_cmp++; if (D_md_stall !== use_d) begin n_bad++; $display("FAIL %s stall t+%0d: got %b expected %b", name, i, D_md_stall, use_d); end
            n_cmp++; if (hi_rd !== old_hi) begin n_bad++; $display("FAIL %s HI held t+%0d: got %h expected %h", name, i, hi_rd, old_hi); end
            n_cmp++; if (lo_rd !== old_lo) begin n_bad++; $display("FAIL %s LO held t+%0d: got %h expected %h", name, i, lo_rd, old_lo); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        E_md_sel = 1'b1; #1 hi_rd = E_md_out;
        E_md_sel = 1'b0; #1 lo_rd = E_md_out;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy after: got %b expected 0", name, busy); end
        n_cmp++; if (D_md_stall !== 1'b0) begin n_bad++; $display("FAIL %s stall after: got %b expected 0", name, D_md_stall); end
        n_cmp++; if (hi_rd !== exp_hi) begin n_bad++; $display("FAIL %s HI result: got %h expected %h", name, hi_rd, exp_hi); end
        n_cmp++; if (lo_rd !== exp_lo) begin n_bad++; $display("FAIL %s LO result: got %h expected %h", name, lo_rd, exp_lo); end
        D_md_use = 1'b0;
        $display("%s A=%h B=%h: HI=%h LO=%h", name, a, b, hi_rd, lo_rd);
    endtask

    task automatic test_mult();
        test_md_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        test_md_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    endtask

    task automatic test_div();
        test_md_op("div_stall", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        test_md_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'h7FFFFFFC, 1'b0);
        test_md_op("div_pos_neg", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'h7FFFFFFC, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        test_md_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000001, 32'hFFFFFFFD, 32'h00000000, 32'h80000000, 1'b0);
    endtask

    task automatic test_div_zero();
        @(posedge clk); #1;
        E_md_en = 1'b1; E_md_op = 3'd4; E_A = 32'h55;
        @(posedge clk); #1;
        E_md_op = 3'd5;
        @(posedge clk); #1;
        E_md_en = 1'b0;
        test_md_op("div_by_zero", 3'd2, 32'h1234, 32'd0, 10, 32'h55, 32'h55, 32'h55, 32'h55, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] hi_rd, lo_rd;
        @(posedge clk); #1;
        E_md_en = 1'b1; E_md_op = 3'd0; E_A = 32'd5; E_B = 32'd7;
        @(posedge clk); #1;
        E_md_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        E_md_sel = 1'b1; #1 hi_rd = E_md_out;
        E_md_sel = 1'b0; #1 lo_rd = E_md_out;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b expected 0", busy); end
        n_cmp++; if (hi_rd !== 32'h0) begin n_bad++; $display("FAIL abort HI: got %h expected 00000000", hi_rd); end
        n_cmp++; if (lo_rd !== 32'h0) begin n_bad++; $display("FAIL abort LO: got %h expected 00000000", lo_rd); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            @(posedge clk); #1;
            E_md_sel = 1'b0; #1 lo_rd = E_md_out;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy t+%0d: got %b expected 0", i, busy); end
            n_cmp++; if (lo_rd !== 32'h0) begin n_bad++; $display("FAIL abort no commit t+%0d: got %h expected 00000000", i, lo_rd); end
        end
        $display("reset mid-run: busy=%b LO=%h", busy, lo_rd);
    endtask

    task automatic test_ignore_during_run();
        logic [31:0] hi_rd, lo_rd;
        logic        exp_busy;
        logic [31:0] exp_lo;
        @(posedge clk); #1;
        E_md_en = 1'b1; E_md_op = 3'd0; E_A = 32'd5; E_B = 32'd7;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            E_md_en = 1'b0;
            if (i == 2) begin
                E_md_en = 1'b1; E_md_op = 3'd0; E_A = 32'd100; E_B = 32'd100;
            end else if (i == 3) begin
                E_md_en = 1'b1; E_md_op = 3'd4; E_A = 32'hDEADBEEF;
            end
            @(negedge clk);
            E_md_sel = 1'b1; #1 hi_rd = E_md_out;
            E_md_sel = 1'b0; #1 lo_rd = E_md_out;
            exp_busy = (i <= 5);
            exp_lo   = (i >= 6) ? 32'h23 : 32'h0;
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL ignore busy t+%0d: got %b expected %b", i, busy, exp_busy); end
            n_cmp++; if (hi_rd !== 32'h0) begin n_bad++; $display("FAIL ignore HI t+%0d: got %h expected 00000000", i, hi_rd); end
            n_cmp++; if (lo_rd !== exp_lo) begin n_bad++; $display("FAIL ignore LO t+%0d: got %h expected %h", i, lo_rd, exp_lo); end
        end
        E_md_en = 1'b0;
        $display("ops during run: HI=%h LO=%h", hi_rd, lo_rd);
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid_run();
        test_ignore_during_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
